// File: rtl/dl11_bus_if.sv
// DL11-style register front end: RCSR/RBUF/XCSR/XBUF for the K1801 bus glue,
// plus rx_read / tx_send handshakes to the serializers and level interrupts.
module dl11_bus_if #(
    parameter bit ERR_EN  = 1'b1,
    parameter bit TIE_RST = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_sel,
    input  logic        bus_wr,
    input  logic        bus_rd,
    input  logic [2:0]  bus_addr,
    input  logic [15:0] bus_din,
    output logic [15:0] bus_dout,
    input  logic [7:0]  rx_byte,
    input  logic        rx_ready,
    output logic        rx_read,
    output logic [7:0]  tx_byte,
    output logic        tx_send,
    input  logic        tx_busy,
    output logic        rx_irq,
    output logic        tx_irq
);

    typedef enum logic [1:0] {R_IDLE, R_ACK, R_WAIT} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_SEND, T_WAITHI, T_WAITLO} tx_state_t;

    rx_state_t   rx_state, rx_next;
    tx_state_t   tx_state, tx_next;

    logic        done, rie, ovr, ready, tie;
    logic [7:0]  rdata;
    logic [1:0]  guard;
    logic [15:0] rd_data;

    logic        rd_en, wr_en, rbuf_rd, rx_cap, xbuf_wr, tx_done;
    logic [1:0]  reg_sel;
    logic        unused_bits;

    assign reg_sel = bus_addr[2:1];
    assign rd_en   = bus_sel & bus_rd;
    assign wr_en   = bus_sel & bus_wr;
    assign rbuf_rd = rd_en & (reg_sel == 2'd1);
    assign rx_cap  = (rx_state == R_IDLE) & rx_ready;
    // XBUF writes are dropped silently while a character is in flight
    assign xbuf_wr = wr_en & (reg_sel == 2'd3) & ready;
    assign tx_done = (tx_state == T_WAITLO) & ~tx_busy;

    assign rx_irq = done & rie;
    assign tx_irq = ready & tie;

    assign unused_bits = ^{bus_addr[0], bus_din[15:8]};

    always_comb begin
        rd_data = 16'h0000;
        case (reg_sel)
            2'd0: rd_data = {8'h00, done, rie, 6'b0};
            2'd1: rd_data = {ERR_EN & ovr, ERR_EN & ovr, 6'b0, rdata};
            2'd2: rd_data = {8'h00, ready, tie, 6'b0};
            default: rd_data = 16'h0000;
        endcase
    end

    always_comb begin
        rx_next = rx_state;
        rx_read = 1'b0;
        case (rx_state)
            R_IDLE: if (rx_ready) rx_next = R_ACK;
            R_ACK: begin
                rx_read = 1'b1;
                rx_next = R_WAIT;
            end
            R_WAIT: if (!rx_ready) rx_next = R_IDLE;
            default: rx_next = R_IDLE;
        endcase
    end

    // Guard lets the FSM proceed if the transmitter never reports busy
    always_comb begin
        tx_next = tx_state;
        tx_send = 1'b0;
        case (tx_state)
            T_IDLE:   if (xbuf_wr) tx_next = T_SEND;
            T_SEND: begin
                tx_send = 1'b1;
                tx_next = T_WAITHI;
            end
            T_WAITHI: if (tx_busy || guard == 2'd3) tx_next = T_WAITLO;
            T_WAITLO: if (!tx_busy) tx_next = T_IDLE;
            default:  tx_next = T_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_state <= R_IDLE;
            tx_state <= T_IDLE;
            done     <= 1'b0;
            rie      <= 1'b0;
            ovr      <= 1'b0;
            rdata    <= 8'h00;
            ready    <= 1'b1;
            tie      <= TIE_RST;
            tx_byte  <= 8'h00;
            guard    <= 2'd0;
            bus_dout <= 16'h0000;
        end else begin
            rx_state <= rx_next;
            tx_state <= tx_next;

            // A capture beats a concurrent RBUF read: the new byte stays pending
            if (rx_cap) begin
                rdata <= rx_byte;
                done  <= 1'b1;
                ovr   <= ERR_EN & done & ~rbuf_rd;
            end else if (rbuf_rd) begin
                done <= 1'b0;
                ovr  <= 1'b0;
            end

            if (wr_en && reg_sel == 2'd0) rie <= bus_din[6];
            if (wr_en && reg_sel == 2'd2) tie <= bus_din[6];

            if (xbuf_wr) begin
                tx_byte <= bus_din[7:0];
                ready   <= 1'b0;
            end else if (tx_done) begin
                ready <= 1'b1;
            end

            guard <= (tx_state == T_WAITHI) ? guard + 2'd1 : 2'd0;

            if (rd_en) bus_dout <= rd_data;
        end
    end

endmodule

// File: tb/tb_dl11_bus_if.sv
// Directed bench for dl11_bus_if; second instance has the error bits disabled.
module tb_dl11_bus_if;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel, wr, rd;
    logic [2:0]  addr;
    logic [15:0] din;
    logic [7:0]  rx_byte;
    logic        rx_ready, tx_busy;

    logic [15:0] dout0, dout1;
    logic        rx_read0, rx_read1, tx_send0, tx_send1;
    logic [7:0]  tx_byte0, tx_byte1;
    logic        rx_irq0, rx_irq1, tx_irq0, tx_irq1;

    int n_pass = 0;
    int n_total = 0;
    int send_cnt = 0;

    always #5 clk = ~clk;

    dl11_bus_if #(.ERR_EN(1'b1)) dut0 (
        .clk(clk), .reset(reset), .bus_sel(sel), .bus_wr(wr), .bus_rd(rd),
        .bus_addr(addr), .bus_din(din), .bus_dout(dout0),
        .rx_byte(rx_byte), .rx_ready(rx_ready), .rx_read(rx_read0),
        .tx_byte(tx_byte0), .tx_send(tx_send0), .tx_busy(tx_busy),
        .rx_irq(rx_irq0), .tx_irq(tx_irq0)
    );

    dl11_bus_if #(.ERR_EN(1'b0)) dut1 (
        .clk(clk), .reset(reset), .bus_sel(sel), .bus_wr(wr), .bus_rd(rd),
        .bus_addr(addr), .bus_din(din), .bus_dout(dout1),
        .rx_byte(rx_byte), .rx_ready(rx_ready), .rx_read(rx_read1),
        .tx_byte(tx_byte1), .tx_send(tx_send1), .tx_busy(tx_busy),
        .rx_irq(rx_irq1), .tx_irq(tx_irq1)
    );

    always @(posedge clk) if (tx_send0) send_cnt <= send_cnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        sel = 1'b1; wr = 1'b1; addr = a; din = d;
        tick();
        sel = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] o0, output logic [15:0] o1);
        sel = 1'b1; rd = 1'b1; addr = a;
        tick();
        sel = 1'b0; rd = 1'b0;
        o0 = dout0; o1 = dout1;
    endtask

    // Present a byte, wait (bounded) for the acknowledge, then drop rx_ready
    task automatic rx_push(input logic [7:0] b);
        int n;
        rx_byte = b; rx_ready = 1'b1;
        n = 0;
        while (!rx_read0 && n < 4) begin
            tick();
            n++;
        end
        chk("rx_push_ack", {15'b0, rx_read0}, 16'h0001);
        rx_ready = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        logic [15:0] d0, d1;
        int sends, n;

        reset = 1'b0; sel = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; din = '0;
        rx_byte = '0; rx_ready = 1'b0; tx_busy = 1'b0;
        tick();
        tick();
        chk("rst_dout", dout0, 16'h0000);
        chk("rst_irqs", {14'b0, rx_irq0, tx_irq0}, 16'h0000);
        chk("rst_hs", {14'b0, rx_read0, tx_send0}, 16'h0000);
        reset = 1'b1;
        bus_read(3'd0, d0, d1); chk("rst_rcsr", d0, 16'h0000);
        bus_read(3'd4, d0, d1); chk("rst_xcsr", d0, 16'h0080);

        // receive one byte with exact acknowledge timing
        rx_byte = 8'h5A; rx_ready = 1'b1;
        tick();
        chk("rx_read_hi", {15'b0, rx_read0}, 16'h0001);
        rx_ready = 1'b0;
        tick();
        chk("rx_read_lo", {15'b0, rx_read0}, 16'h0000);
        tick();
        bus_read(3'd0, d0, d1); chk("rx_rcsr_done", d0, 16'h0080);
        bus_read(3'd2, d0, d1); chk("rx_rbuf", d0, 16'h005A);
        tick();
        chk("dout_hold", dout0, 16'h005A);
        bus_read(3'd0, d0, d1); chk("rx_rcsr_clr", d0, 16'h0000);
        bus_write(3'd2, 16'h00FF);
        bus_read(3'd2, d0, d1); chk("rbuf_wr_ign", d0, 16'h005A);
        bus_read(3'd6, d0, d1); chk("xbuf_rd0", d0, 16'h0000);

        // overrun
        rx_push(8'h11);
        rx_push(8'h22);
        bus_read(3'd2, d0, d1);
        chk("ovr_rbuf", d0, 16'hC022);
        chk("ovr_rbuf_noerr", d1, 16'h0022);
        bus_read(3'd0, d0, d1);
        chk("ovr_rcsr", d0, 16'h0000);
        chk("ovr_rcsr_noerr", d1, 16'h0000);
        bus_read(3'd2, d0, d1); chk("ovr_cleared", d0, 16'h0022);

        // receive interrupt
        bus_write(3'd0, 16'h0040);
        chk("rxirq_idle", {15'b0, rx_irq0}, 16'h0000);
        rx_push(8'h99);
        chk("rxirq_set", {15'b0, rx_irq0}, 16'h0001);
        bus_read(3'd0, d0, d1); chk("rxirq_rcsr", d0, 16'h00C0);
        bus_read(3'd2, d0, d1); chk("rxirq_rbuf", d0, 16'h0099);
        chk("rxirq_clr", {15'b0, rx_irq0}, 16'h0000);
        bus_write(3'd0, 16'h0000);

        // transmit
        sends = send_cnt;
        bus_write(3'd4, 16'h0040);
        chk("txirq_ready", {15'b0, tx_irq0}, 16'h0001);
        bus_write(3'd6, 16'h0041);
        chk("tx_send_hi", {15'b0, tx_send0}, 16'h0001);
        chk("tx_byte", {8'h00, tx_byte0}, 16'h0041);
        chk("txirq_busy", {15'b0, tx_irq0}, 16'h0000);
        bus_read(3'd4, d0, d1); chk("tx_xcsr_busy", d0, 16'h0040);
        tx_busy = 1'b1;
        repeat (99) tick();
        chk("tx_still_busy", {15'b0, tx_irq0}, 16'h0000);
        tx_busy = 1'b0;
        tick();
        chk("txirq_done", {15'b0, tx_irq0}, 16'h0001);
        bus_read(3'd4, d0, d1); chk("tx_xcsr_done", d0, 16'h00C0);
        chk("tx_one_send", 16'(send_cnt - sends), 16'h0001);

        // write while busy is dropped; guard releases with no busy pulse
        sends = send_cnt;
        bus_write(3'd6, 16'h0055);
        bus_write(3'd6, 16'h0033);
        chk("busy_wr_ign", {8'h00, tx_byte0}, 16'h0055);
        n = 0;
        while (!tx_irq0 && n < 8) begin
            tick();
            n++;
        end
        chk("guard_lat", 16'(n), 16'h0005);
        chk("guard_one_send", 16'(send_cnt - sends), 16'h0001);

        // RBUF read colliding with a new capture
        rx_push(8'h66);
        sel = 1'b1; rd = 1'b1; addr = 3'd2;
        rx_byte = 8'h77; rx_ready = 1'b1;
        tick();
        sel = 1'b0; rd = 1'b0;
        chk("coll_old", dout0, 16'h0066);
        chk("coll_ack", {15'b0, rx_read0}, 16'h0001);
        rx_ready = 1'b0;
        tick();
        tick();
        bus_read(3'd0, d0, d1); chk("coll_rcsr", d0, 16'h0080);
        bus_read(3'd2, d0, d1); chk("coll_rbuf", d0, 16'h0077);

        // reset while waiting for the transmitter to go idle
        sends = send_cnt;
        bus_write(3'd6, 16'h0012);
        tick();
        tx_busy = 1'b1;
        tick();
        chk("rst_mid_busy", {15'b0, tx_irq0}, 16'h0000);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rst_mid_send", {15'b0, tx_send0}, 16'h0000);
        bus_read(3'd4, d0, d1); chk("rst_mid_xcsr", d0, 16'h0080);
        repeat (3) tick();
        chk("rst_mid_nosend", 16'(send_cnt - sends), 16'h0001);
        chk("rst_mid_txbyte", {8'h00, tx_byte0}, 16'h0000);
        tx_busy = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dl11_bus_if.md
Name: dl11_bus_if

Overview:
- CPU-side register front end for the serial receiver and transmitter pair.
- Presents the four DL11-compatible registers (RCSR, RBUF, XCSR, XBUF) to the K1801 bus glue.
- Drives the receiver's rxread and the transmitter's sbyte/send handshakes.
- Raises level interrupt requests. Vectors and bus address decode are handled outside this block.

Parameters:
- ERR_EN, 1, when 1, RBUF bits 15 (error) and 14 (overrun) are implemented; when 0 they read as 0.
- TIE_RST, 0, reset value of the XCSR interrupt-enable bit.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- bus_sel  in  1  block selected this cycle
- bus_wr  in  1  one-cycle write strobe, qualified by bus_sel
- bus_rd  in  1  one-cycle read strobe, qualified by bus_sel
- bus_addr  in  3  byte offset; 0=RCSR, 2=RBUF, 4=XCSR, 6=XBUF; bit0 ignored
- bus_din  in  16  write data
- bus_dout  out  16  read data, registered
- rx_byte  in  8  receiver data
- rx_ready  in  1  receiver byte-available; held until rx_read
- rx_read  out  1  one-cycle acknowledge to receiver
- tx_byte  out  8  transmitter data
- tx_send  out  1  one-cycle start pulse to transmitter
- tx_busy  in  1  transmitter busy; rises 1-2 cycles after tx_send
- rx_irq  out  1  level interrupt request, receive
- tx_irq  out  1  level interrupt request, transmit

Behaviour:
- All state updates on posedge clk. When reset=0 at an edge:
  - RCSR.DONE(7)=0, RCSR.RIE(6)=0, RBUF=0, overrun=0.
  - XCSR.READY(7)=1, XCSR.TIE(6)=TIE_RST.
  - bus_dout=0, rx_read=0, tx_send=0, tx_byte=0.
  - RX FSM=R_IDLE, TX FSM=T_IDLE.
  - This applies mid-operation too; a transmission already started in the serializer is simply no longer tracked.
- Read path:
  - bus_dout is updated the cycle after bus_sel&bus_rd.
  - RCSR = {8'b0, DONE, RIE, 6'b0}.
  - RBUF = {ERR, OVR, 6'b0, data}, where ERR = OVR.
  - XCSR = {8'b0, READY, TIE, 6'b0}.
  - XBUF reads 0.
  - Reading RBUF clears DONE and OVR in the same edge. Unselected cycles hold bus_dout.
- Write path:
  - RCSR write updates RIE from bus_din[6]; all other bits are read-only.
  - XCSR write updates TIE from bus_din[6].
  - RBUF write is ignored.
  - XBUF write with READY=1: tx_byte<=bus_din[7:0], READY<=0, TX FSM enters T_SEND.
  - XBUF write with READY=0 is ignored entirely (no data change, no error).
- RX FSM:
  - R_IDLE: on rx_ready=1, latch rx_byte into RBUF[7:0], set DONE, set OVR if DONE was already 1 and not cleared this cycle. Drive rx_read=1 next cycle, go R_ACK.
  - R_ACK: rx_read=1 for exactly one cycle, go R_WAIT.
  - R_WAIT: stay until rx_ready=0, then R_IDLE.
  - Capture-to-rx_read latency is 1 cycle.
- Simultaneous RBUF read and capture:
  - The read returns the old byte.
  - The capture wins: DONE ends at 1 and OVR ends at 0.
- TX FSM:
  - T_IDLE: idle.
  - T_SEND: tx_send=1 for one cycle, go T_WAITHI.
  - T_WAITHI: wait for tx_busy=1, or 4 cycles elapsed (guard counter), then T_WAITLO.
  - T_WAITLO: wait for tx_busy=0, then set READY=1 and go T_IDLE.
  - Write-to-tx_send latency is 1 cycle.
- Interrupts (combinational from registers, no edge latching):
  - rx_irq = DONE & RIE.
  - tx_irq = READY & TIE.
- A READY rise and an XCSR write in the same cycle: READY rises and TIE takes the written value.

Test Plan:
- Reset: hold reset=0 for 2 clocks -> RCSR reads 0x0000, XCSR reads 0x0080, rx_irq=0, tx_irq=0, rx_read=0, tx_send=0.
- Receive: rx_byte=0x5A, rx_ready=1 until rx_read, then 0.
  - Next cycle rx_read=1 for exactly 1 cycle.
  - RCSR reads 0x0080; RBUF reads 0x005A; a following RCSR read gives 0x0000.
- Overrun: two bytes 0x11 then 0x22 with no RBUF read between -> RBUF reads 0xC022, then RCSR reads 0x0000.
  - Repeat with ERR_EN=0 -> RBUF reads 0x0022.
- Transmit: write XCSR 0x0040, then XBUF 0x0041.
  - Next cycle tx_send=1 with tx_byte=0x41; XCSR reads 0x0040 and tx_irq=0.
  - Model tx_busy high 2 cycles after tx_send for 100 cycles -> XCSR returns to 0x00C0 one cycle after tx_busy falls; tx_irq=1.
- Busy write and guard: write XBUF 0x33 while READY=0 -> tx_byte unchanged, no extra tx_send.
  - With tx_busy tied 0, READY returns to 1 within 6 cycles of the accepted write.
- Collision and reset mid-operation:
  - RBUF read in the same cycle as a new capture 0x77 -> read returns the old byte; afterwards RCSR=0x0080 and RBUF=0x0077.
  - Assert reset during T_WAITLO -> XCSR=0x0080 next read, tx_send stays 0.
